cic_rate_sequencer: RTL and testbench
=====================================

# cic_rate_sequencer

Run-time decimation controller for one `cic` decimator in the receiver chain. It accepts host decimation-change requests and applies them only on a CIC output-frame boundary, so the CIC sample counter can never overrun. It gates the CIC input strobe around the switch and blanks the first `STAGES` post-change outputs, whose comb history mixes the old and new rates. It sits between the upstream sample strobe/host register file and the CIC, and drives the downstream output-valid qualifier.

## Interface
- `STAGES`, 5: CIC sections; also the number of outputs discarded after any rate change or reset.
- `MIN_DECIMATION`, 2: lowest legal decimation.
- `MAX_DECIMATION`, 40: highest legal decimation.
- `INIT_DECIMATION`, 40: decimation loaded on reset; must lie in [MIN, MAX].
- `TIMEOUT_CYCLES`, 65535: ALIGN watchdog limit; used only with `CIC_SEQ_TIMEOUT_EN`.

Ports:
- `clock` in 1: single clock domain.
- `reset` in 1: synchronous, active-high.
- `req_decimation` in 7: requested decimation.
- `req_valid` in 1: request qualifier; accepted when `req_valid && req_ready`.
- `req_ready` out 1: high only in RUN.
- `req_ack` out 1: one-cycle pulse when a request completes (rate applied and settled, or same-rate no-op).
- `rate_error` out 1: one-cycle pulse on a rejected or aborted request.
- `in_strobe` in 1: upstream sample strobe.
- `cic_in_strobe` out 1: gated strobe to CIC `in_strobe`.
- `cic_decimation` out 7: registered decimation to CIC.
- `cic_out_strobe` in 1: CIC `out_strobe`.
- `out_valid` out 1: qualified output strobe to downstream.
- `busy` out 1: high in any state other than RUN.

## Operation
- States: RUN, ALIGN, SWITCH, SETTLE.
- RUN:
  - `out_valid = cic_out_strobe`.
  - Accepted request outside [MIN, MAX]: pulse `rate_error` next cycle, stay in RUN.
  - Accepted request equal to `cic_decimation`: pulse `req_ack` next cycle, stay in RUN.
  - Any other accepted request: latch `pending`, go to ALIGN.
- ALIGN:
  - `out_valid = cic_out_strobe`; that output is still at the old rate and is valid.
  - On `cic_out_strobe` (CIC counter is 0), go to SWITCH.
- SWITCH (exactly 1 cycle):
  - `cic_decimation <= pending`.
  - `cic_in_strobe` forced 0; the dropped sample is acceptable because its output is discarded.
  - Go to SETTLE.
- SETTLE:
  - `out_valid` forced 0.
  - 3-bit-or-wider counter counts `cic_out_strobe` pulses.
  - On the `STAGES`th pulse, go to RUN and pulse `req_ack` the following cycle. That `STAGES`th output is also discarded.
- Outside SWITCH, `cic_in_strobe = in_strobe` (combinational, zero latency).
- `out_valid` is combinational from `cic_out_strobe` and the state register.
- Requests presented while `req_ready` = 0 are not accepted; the host must hold `req_valid`.
- Reset, including mid-ALIGN/SETTLE: pending request is dropped, no `req_ack`/`rate_error`, `cic_decimation <= INIT_DECIMATION`, state <= SETTLE with counter 0. CIC integrators are never cleared, so this post-reset settle is mandatory.
- Input stream stalled in ALIGN: wait indefinitely (default build).

## Timing
- Reset values:
  - Registered outputs: `cic_decimation` = INIT, `req_ack` = 0, `rate_error` = 0.
  - Combinational outputs while state = SETTLE: `req_ready` = 0, `busy` = 1, `out_valid` = 0, `cic_in_strobe` = `in_strobe`.
- Accept in cycle t → `busy` = 1 at t+1 (ALIGN).
- `cic_out_strobe` at cycle a while in ALIGN → SWITCH at a+1 → new `cic_decimation` visible at a+2 → SETTLE from a+2.
- `req_ack` fires 1 cycle after the `STAGES`th settle strobe.
- Simultaneous `req_valid` with reset: reset wins.
- `in_strobe` coincident with SWITCH: that sample is dropped.

## Configuration
- `CIC_SEQ_TIMEOUT_EN` defined:
  - A 16-bit-or-wider watchdog counts cycles in ALIGN.
  - On reaching `TIMEOUT_CYCLES` without `cic_out_strobe`: drop the request, pulse `rate_error`, return to RUN, leave `cic_decimation` unchanged.
  - The counter clears on entering ALIGN and on reset.
- Undefined: no watchdog logic; ALIGN waits indefinitely.

## Test plan
- Reset, then `in_strobe` every cycle, INIT = 40: `cic_decimation` = 40; first 5 `cic_out_strobe` give `out_valid` = 0, the 6th gives `out_valid` = 1; `busy` falls on the cycle after the 5th.
- In RUN at 40, request 10: `req_ready` drops; next old-rate output is still valid; SWITCH drops exactly one `cic_in_strobe`; `cic_decimation` = 10; 5 outputs blanked; `req_ack` pulses once; outputs then spaced 10 strobes apart.
- Request 1 and request 41: `rate_error` pulses each; `cic_decimation` unchanged; `busy` stays 0.
- Request equal to current (40): `req_ack` next cycle; no SWITCH, no blanking.
- Assert `reset` during SETTLE after a 40→8 change: `cic_decimation` = 40; no `req_ack`; a fresh 5-output settle is blanked.
- With `CIC_SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 100, `in_strobe` held 0, request 20: `rate_error` after 100 ALIGN cycles; `cic_decimation` stays 40; back in RUN.

Source files
------------

// File: rtl/cic_rate_sequencer_if.sv
// Host/strobe bundle between the rate sequencer, its host side and the CIC.
// slave  : the sequencer itself.
// master : whoever drives requests, the input strobe and the CIC out_strobe.
interface cic_rate_sequencer_if;
  logic [6:0] req_decimation;
  logic       req_valid;
  logic       req_ready;
  logic       req_ack;
  logic       rate_error;
  logic       in_strobe;
  logic       cic_in_strobe;
  logic [6:0] cic_decimation;
  logic       cic_out_strobe;
  logic       out_valid;
  logic       busy;

  modport slave (
    input  req_decimation, req_valid, in_strobe, cic_out_strobe,
    output req_ready, req_ack, rate_error, cic_in_strobe, cic_decimation,
           out_valid, busy
  );

  modport master (
    output req_decimation, req_valid, in_strobe, cic_out_strobe,
    input  req_ready, req_ack, rate_error, cic_in_strobe, cic_decimation,
           out_valid, busy
  );
endinterface

// File: rtl/cic_rate_sequencer.sv
// Run-time decimation controller for one CIC decimator.
// Rate changes are applied only on a CIC output-frame boundary; the input
// strobe is gated for the switch cycle and the first STAGES outputs after any
// change (or reset) are blanked because their comb history mixes rates.
// Optional feature: define CIC_SEQ_TIMEOUT_EN to add an ALIGN watchdog that
// aborts a request after TIMEOUT_CYCLES cycles with no CIC output.
module cic_rate_sequencer #(
  parameter int STAGES          = 5,
  parameter int MIN_DECIMATION  = 2,
  parameter int MAX_DECIMATION  = 40,
  parameter int INIT_DECIMATION = 40,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input logic                 clock,
  input logic                 reset,
  cic_rate_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_SWITCH = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  // Settle counter must hold 0..STAGES-1; never narrower than 3 bits.
  localparam int CW = ($clog2(STAGES) > 3) ? $clog2(STAGES) : 3;

  localparam logic [6:0]    MIN_D  = 7'(MIN_DECIMATION);
  localparam logic [6:0]    MAX_D  = 7'(MAX_DECIMATION);
  localparam logic [6:0]    INIT_D = 7'(INIT_DECIMATION);
  localparam logic [CW-1:0] LAST_S = CW'(STAGES - 1);

  state_t        state_q;
  logic [6:0]    cic_dec_q;
  logic [6:0]    pending_q;
  logic [CW-1:0] settle_cnt_q;
  logic          req_ack_q;
  logic          rate_error_q;
  // Set only by a real rate switch, so the reset-time settle never acks.
  logic          ack_pend_q;

`ifdef CIC_SEQ_TIMEOUT_EN
  localparam int WW = ($clog2(TIMEOUT_CYCLES + 1) > 16) ? $clog2(TIMEOUT_CYCLES + 1) : 16;
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
  logic [WW-1:0] wd_cnt_q;
`endif

  logic accept;
  logic req_in_range;
  assign accept       = bus.req_valid && (state_q == ST_RUN);
  assign req_in_range = (bus.req_decimation >= MIN_D) && (bus.req_decimation <= MAX_D);

  // Sequencer FSM with registered decimation, ack and error pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_SETTLE;
      cic_dec_q    <= INIT_D;
      pending_q    <= INIT_D;
      settle_cnt_q <= '0;
      req_ack_q    <= 1'b0;
      rate_error_q <= 1'b0;
      ack_pend_q   <= 1'b0;
`ifdef CIC_SEQ_TIMEOUT_EN
      wd_cnt_q     <= '0;
`endif
    end else begin
      req_ack_q    <= 1'b0;
      rate_error_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (accept) begin
            if (!req_in_range) begin
              rate_error_q <= 1'b1;
            end else if (bus.req_decimation == cic_dec_q) begin
              req_ack_q <= 1'b1;
            end else begin
              pending_q <= bus.req_decimation;
              state_q   <= ST_ALIGN;
`ifdef CIC_SEQ_TIMEOUT_EN
              wd_cnt_q  <= '0;
`endif
            end
          end
        end
        ST_ALIGN: begin
          // The CIC counter is at zero right at its output strobe.
          if (bus.cic_out_strobe) begin
            state_q <= ST_SWITCH;
          end
`ifdef CIC_SEQ_TIMEOUT_EN
          else if (wd_cnt_q == WD_LAST) begin
            rate_error_q <= 1'b1;
            state_q      <= ST_RUN;
          end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
`endif
        end
        ST_SWITCH: begin
          cic_dec_q    <= pending_q;
          settle_cnt_q <= '0;
          ack_pend_q   <= 1'b1;
          state_q      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (bus.cic_out_strobe) begin
            if (settle_cnt_q == LAST_S) begin
              settle_cnt_q <= '0;
              state_q      <= ST_RUN;
              req_ack_q    <= ack_pend_q;
              ack_pend_q   <= 1'b0;
            end else begin
              settle_cnt_q <= settle_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_SETTLE;
      endcase
    end
  end

  // Zero-latency strobe gating and output qualification from the state.
  always_comb begin
    bus.req_ready     = (state_q == ST_RUN);
    bus.busy          = (state_q != ST_RUN);
    bus.cic_in_strobe = bus.in_strobe && (state_q != ST_SWITCH);
    bus.out_valid     = bus.cic_out_strobe &&
                        ((state_q == ST_RUN) || (state_q == ST_ALIGN));
  end

  assign bus.cic_decimation = cic_dec_q;
  assign bus.req_ack        = req_ack_q;
  assign bus.rate_error     = rate_error_q;

endmodule

// File: tb/tb_cic_rate_sequencer.sv
// Directed bench for cic_rate_sequencer: a vector table for the reset settle,
// rejects, no-op and a full change, then hand sequences for reset during
// settle and the ALIGN stall behaviour.
module tb_cic_rate_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cic_rate_sequencer_if bus();

  cic_rate_sequencer #(
    .STAGES(5), .MIN_DECIMATION(2), .MAX_DECIMATION(40),
    .INIT_DECIMATION(40), .TIMEOUT_CYCLES(100)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       rst, rv;
    logic [6:0] rd;
    logic       ins, cos;
    logic       e_rdy, e_ack, e_err, e_cin;
    logic [6:0] e_dec;
    logic       e_ov, e_busy;
  } vec_t;

  vec_t tbl[$];
  int   n_run  = 0;
  int   n_fail = 0;

  function automatic void add(logic r, logic rv, logic [6:0] rd, logic ins, logic cos,
                              logic rdy, logic ack, logic err, logic cin,
                              logic [6:0] dec, logic ov, logic busy);
    vec_t v;
    v.rst = r; v.rv = rv; v.rd = rd; v.ins = ins; v.cos = cos;
    v.e_rdy = rdy; v.e_ack = ack; v.e_err = err; v.e_cin = cin;
    v.e_dec = dec; v.e_ov = ov; v.e_busy = busy;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  // One clock cycle: inputs change just after the edge, sampling at negedge.
  task automatic cyc(input logic r, input logic rv, input logic [6:0] rd,
                     input logic ins, input logic cos);
    @(posedge clk); #1;
    rst = r; bus.req_valid = rv; bus.req_decimation = rd;
    bus.in_strobe = ins; bus.cic_out_strobe = cos;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; bus.req_valid = 1'b0; bus.req_decimation = '0;
    bus.in_strobe = 1'b1; bus.cic_out_strobe = 1'b0;
    repeat (2) @(posedge clk);

    //   rst rv rd  ins cos | rdy ack err cin dec ov busy
    add(1, 0, 0,  1, 1,   0, 0, 0, 1, 40, 0, 1); // 0 in reset: blanked
    add(0, 0, 0,  1, 1,   0, 0, 0, 1, 40, 0, 1); // 1 settle 1
    add(0, 0, 0,  1, 0,   0, 0, 0, 1, 40, 0, 1); // 2
    add(0, 0, 0,  1, 1,   0, 0, 0, 1, 40, 0, 1); // 3 settle 2
    add(0, 0, 0,  1, 1,   0, 0, 0, 1, 40, 0, 1); // 4 settle 3
    add(0, 0, 0,  1, 1,   0, 0, 0, 1, 40, 0, 1); // 5 settle 4
    add(0, 0, 0,  1, 1,   0, 0, 0, 1, 40, 0, 1); // 6 settle 5 (blanked)
    add(0, 0, 0,  1, 0,   1, 0, 0, 1, 40, 0, 0); // 7 RUN, no ack after reset
    add(0, 0, 0,  1, 1,   1, 0, 0, 1, 40, 1, 0); // 8 6th output valid
    add(0, 1, 1,  1, 0,   1, 0, 0, 1, 40, 0, 0); // 9 req 1 (below MIN)
    add(0, 1, 41, 1, 0,   1, 0, 1, 1, 40, 0, 0); // 10 err for 1; req 41
    add(0, 0, 0,  1, 0,   1, 0, 1, 1, 40, 0, 0); // 11 err for 41
    add(0, 1, 40, 1, 0,   1, 0, 0, 1, 40, 0, 0); // 12 same-rate request
    add(0, 0, 0,  1, 0,   1, 1, 0, 1, 40, 0, 0); // 13 no-op ack
    add(0, 1, 2,  1, 0,   1, 0, 0, 1, 40, 0, 0); // 14 req MIN=2 accepted
    add(0, 0, 0,  1, 0,   0, 0, 0, 1, 40, 0, 1); // 15 ALIGN
    add(0, 0, 0,  1, 1,   0, 0, 0, 1, 40, 1, 1); // 16 old-rate output valid
    add(0, 0, 0,  1, 0,   0, 0, 0, 0, 40, 0, 1); // 17 SWITCH drops strobe
    add(0, 0, 0,  1, 0,   0, 0, 0, 1, 2,  0, 1); // 18 SETTLE, new rate
    add(0, 0, 0,  1, 1,   0, 0, 0, 1, 2,  0, 1); // 19
    add(0, 0, 0,  1, 1,   0, 0, 0, 1, 2,  0, 1); // 20
    add(0, 0, 0,  1, 1,   0, 0, 0, 1, 2,  0, 1); // 21
    add(0, 0, 0,  1, 1,   0, 0, 0, 1, 2,  0, 1); // 22
    add(0, 0, 0,  1, 1,   0, 0, 0, 1, 2,  0, 1); // 23 5th blanked
    add(0, 0, 0,  1, 0,   1, 1, 0, 1, 2,  0, 0); // 24 ack
    add(0, 1, 40, 1, 0,   1, 0, 0, 1, 2,  0, 0); // 25 req MAX=40
    add(0, 1, 40, 1, 0,   0, 0, 0, 1, 2,  0, 1); // 26 held, not re-accepted
    add(0, 0, 0,  1, 1,   0, 0, 0, 1, 2,  1, 1); // 27 align strobe
    add(0, 0, 0,  1, 0,   0, 0, 0, 0, 2,  0, 1); // 28 SWITCH
    add(0, 0, 0,  1, 0,   0, 0, 0, 1, 40, 0, 1); // 29 SETTLE at 40

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rst, tbl[i].rv, tbl[i].rd, tbl[i].ins, tbl[i].cos);
      chk("req_ready",  i, 32'(bus.req_ready),      32'(tbl[i].e_rdy));
      chk("req_ack",    i, 32'(bus.req_ack),        32'(tbl[i].e_ack));
      chk("rate_error", i, 32'(bus.rate_error),     32'(tbl[i].e_err));
      chk("cic_in_stb", i, 32'(bus.cic_in_strobe),  32'(tbl[i].e_cin));
      chk("cic_dec",    i, 32'(bus.cic_decimation), 32'(tbl[i].e_dec));
      chk("out_valid",  i, 32'(bus.out_valid),      32'(tbl[i].e_ov));
      chk("busy",       i, 32'(bus.busy),           32'(tbl[i].e_busy));
    end

    // Finish the 2->40 settle: five blanked outputs, then one ack.
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 1, 1);
      chk("b_ov_blank", k, 32'(bus.out_valid), 32'd0);
    end
    cyc(0, 0, 0, 1, 0);
    chk("b_ack", 0, 32'(bus.req_ack), 32'd1);
    chk("b_busy", 0, 32'(bus.busy), 32'd0);
    cyc(0, 0, 0, 1, 0);
    chk("b_ack_once", 0, 32'(bus.req_ack), 32'd0);

    // 40->8, then reset in the middle of SETTLE.
    cyc(0, 1, 8, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("c_align_busy", 0, 32'(bus.busy), 32'd1);
    cyc(0, 0, 0, 1, 1);
    chk("c_align_ov", 0, 32'(bus.out_valid), 32'd1);
    cyc(0, 0, 0, 1, 0);
    chk("c_switch_cin", 0, 32'(bus.cic_in_strobe), 32'd0);
    cyc(0, 0, 0, 1, 0);
    chk("c_dec8", 0, 32'(bus.cic_decimation), 32'd8);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(1, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("c_dec_init", 0, 32'(bus.cic_decimation), 32'd40);
    chk("c_busy", 0, 32'(bus.busy), 32'd1);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 1, 1);
      chk("c_ov_blank", k, 32'(bus.out_valid), 32'd0);
      chk("c_no_ack", k, 32'(bus.req_ack), 32'd0);
    end
    cyc(0, 0, 0, 1, 0);
    chk("c_no_ack_end", 0, 32'(bus.req_ack), 32'd0);
    chk("c_run", 0, 32'(bus.busy), 32'd0);
    cyc(0, 0, 0, 1, 1);
    chk("c_ov_valid", 0, 32'(bus.out_valid), 32'd1);

    // Request 20 with the input stream stalled.
    cyc(0, 1, 20, 0, 0);
`ifdef CIC_SEQ_TIMEOUT_EN
    for (int k = 0; k < 100; k++) begin
      cyc(0, 0, 0, 0, 0);
      chk("d_wait_busy", k, 32'(bus.busy), 32'd1);
      chk("d_wait_err", k, 32'(bus.rate_error), 32'd0);
    end
    cyc(0, 0, 0, 0, 0);
    chk("d_timeout_err", 0, 32'(bus.rate_error), 32'd1);
    chk("d_run", 0, 32'(bus.busy), 32'd0);
    chk("d_dec", 0, 32'(bus.cic_decimation), 32'd40);
    cyc(0, 0, 0, 0, 0);
    chk("d_err_once", 0, 32'(bus.rate_error), 32'd0);
`else
    for (int k = 0; k < 150; k++) begin
      cyc(0, 0, 0, 0, 0);
      if (bus.busy !== 1'b1 || bus.rate_error !== 1'b0 || k == 149) begin
        chk("d_stall_busy", k, 32'(bus.busy), 32'd1);
        chk("d_stall_err", k, 32'(bus.rate_error), 32'd0);
      end
    end
    cyc(0, 0, 0, 1, 1);
    chk("d_late_ov", 0, 32'(bus.out_valid), 32'd1);
    cyc(0, 0, 0, 1, 0);
    chk("d_switch_cin", 0, 32'(bus.cic_in_strobe), 32'd0);
    cyc(0, 0, 0, 1, 0);
    chk("d_dec20", 0, 32'(bus.cic_decimation), 32'd20);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 1, 1);
      chk("d_ov_blank", k, 32'(bus.out_valid), 32'd0);
    end
    cyc(0, 0, 0, 1, 0);
    chk("d_ack", 0, 32'(bus.req_ack), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
